// File: rtl/output_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : output_mem_pkg
//  Description : Shared types, word geometry and the saturating lane adder
//                used by the output-memory accumulation controller.
//  Revision    : 1.0  initial release
// ============================================================================
package output_mem_pkg;

    // Controller operating mode: accepting tiles or sweeping zeros.
    typedef enum logic [0:0] {
        CTRL_RUN   = 1'b0,
        CTRL_CLEAR = 1'b1
    } ctrl_state_t;

    localparam int LANES  = 32;
    localparam int LANE_W = 16;
    localparam int WORD_W = LANES * LANE_W;

    // Signed 16-bit add clamped to [-32768, 32767].
    // Bit 16 of the result reports that a clamp happened, bits 15:0 are the sum.
    function automatic logic [16:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            return {1'b1, (s[16] ? 16'h8000 : 16'h7FFF)};
        end
        return {1'b0, s[15:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_accum_ctrl_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. A lone request wins at once;
//                with both requesting, the one not granted last time wins.
//                Grant is combinational and one-hot (or zero).
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // Index of the requester granted most recently.
    logic last_q;

    // Pick a winner for this cycle from the request pattern and history.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Remember who won so the other side gets priority next contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b0;
        end else if (|gnt_o) begin
            last_q <= gnt_o[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : output_accum_ctrl
//  Description : Read-modify-write scheduler for the two-port output SRAM.
//                Granted tiles read on port 1 in the grant cycle, are added
//                lane-wise (saturating) in the next cycle and written on
//                port 2 in that same cycle. Back-to-back hits on one address
//                use the previous sum instead of the stale SRAM read.
//                Also sweeps zeros over the whole memory on request.
//  Revision    : 1.0  initial release
// ============================================================================
module output_accum_ctrl
    import output_mem_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [1:0]            req_first_i,
    input  logic [2*WORD_W-1:0]   req_data_i,
    input  logic                  clear_start_i,
    output logic                  clear_busy_o,
    output logic                  clear_done_o,
    output logic                  rd_valid_o,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [WORD_W-1:0]     rd_data_i,
    output logic                  wr_valid_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [WORD_W-1:0]     wr_data_o,
    output logic                  sat_flag_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Control state
    ctrl_state_t         state_q;
    logic                clear_pend_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                clear_done_q;
    logic                sat_q;

    // Add/write stage registers (tile granted in the previous cycle)
    logic                b_valid_q;
    logic [ADDR_W-1:0]   b_addr_q;
    logic [WORD_W-1:0]   b_data_q;
    logic                b_first_q;
    logic                b_fwd_q;
    logic [WORD_W-1:0]   last_wr_q;

    // Grant-cycle signals
    logic                w_accept;
    logic [1:0]          w_gnt;
    logic                w_any;
    logic                w_sel;
    logic [ADDR_W-1:0]   w_a_addr;
    logic                w_a_first;
    logic [WORD_W-1:0]   w_a_data;
    logic                w_a_fwd;

    // Add-stage signals
    logic [WORD_W-1:0]   w_base;
    logic [WORD_W-1:0]   w_sum;
    logic [LANES-1:0]    w_lane_sat;
    logic                w_any_sat;

    // New grants stop as soon as a clear is requested so the pipeline drains
    // in at most one cycle; reset also holds every requester off.
    assign w_accept = !reset && (state_q == CTRL_RUN) && !clear_pend_q && !clear_start_i;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req_valid_i),
        .en_i  (w_accept),
        .gnt_o (w_gnt)
    );

    assign req_ready_o = w_gnt;
    assign w_any       = |w_gnt;
    assign w_sel       = w_gnt[1];

    assign w_a_addr  = w_sel ? req_addr_i[2*ADDR_W-1 -: ADDR_W] : req_addr_i[ADDR_W-1:0];
    assign w_a_first = w_sel ? req_first_i[1] : req_first_i[0];
    assign w_a_data  = w_sel ? req_data_i[2*WORD_W-1 -: WORD_W] : req_data_i[WORD_W-1:0];

    // The tile now in the add stage writes this cycle, so an SRAM read of
    // the same word returns the old value; flag it to use the fresh sum.
    assign w_a_fwd = b_valid_q && (w_a_addr == b_addr_q);

    // A first partial needs no stored value, so its read is skipped.
    assign rd_valid_o = w_any && !w_a_first;
    assign rd_addr_o  = w_any ? w_a_addr : '0;

    // Capture the granted tile and keep the most recent written sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_valid_q <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            b_first_q <= 1'b0;
            b_fwd_q   <= 1'b0;
            last_wr_q <= '0;
        end else begin
            b_valid_q <= w_any;
            if (w_any) begin
                b_addr_q  <= w_a_addr;
                b_data_q  <= w_a_data;
                b_first_q <= w_a_first;
                b_fwd_q   <= w_a_fwd;
            end
            if (b_valid_q) begin
                last_wr_q <= w_sum;
            end
        end
    end

    // Select the value the partial sums are added to.
    always_comb begin
        w_base = '0;
        if (!b_first_q) begin
            w_base = b_fwd_q ? last_wr_q : rd_data_i;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W:0] w_res;
        assign w_res = sat_add16(w_base[gi*LANE_W +: LANE_W], b_data_q[gi*LANE_W +: LANE_W]);
        assign w_sum[gi*LANE_W +: LANE_W] = w_res[LANE_W-1:0];
        assign w_lane_sat[gi]             = w_res[LANE_W];
    end

    assign w_any_sat = b_valid_q && (|w_lane_sat);

    // Run/clear sequencing, clear counter, done pulse and sticky saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CTRL_RUN;
            clear_pend_q <= 1'b0;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            if (w_any_sat) begin
                sat_q <= 1'b1;
            end
            case (state_q)
                CTRL_RUN: begin
                    if (clear_start_i || clear_pend_q) begin
                        if (!b_valid_q) begin
                            state_q      <= CTRL_CLEAR;
                            clear_pend_q <= 1'b0;
                            clr_cnt_q    <= '0;
                            sat_q        <= 1'b0;
                        end else begin
                            clear_pend_q <= 1'b1;
                        end
                    end
                end
                CTRL_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q      <= CTRL_RUN;
                        clear_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= CTRL_RUN;
                end
            endcase
        end
    end

    assign clear_busy_o = (state_q == CTRL_CLEAR);
    assign clear_done_o = clear_done_q;
    assign sat_flag_o   = sat_q;

    // Port 2 carries either the sweep (zeros) or the accumulated tile.
    assign wr_valid_o = b_valid_q || (state_q == CTRL_CLEAR);
    assign wr_addr_o  = (state_q == CTRL_CLEAR) ? clr_cnt_q : (b_valid_q ? b_addr_q : '0);
    assign wr_data_o  = b_valid_q ? w_sum : '0;

endmodule
`default_nettype wire

// File: tb/tb_output_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_accum_ctrl
//  Description : Scoreboard bench for output_accum_ctrl with an attached
//                two-port SRAM model and a word-level accumulation model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_output_accum_ctrl;
    import output_mem_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*ADDR_W-1:0] req_addr;
    logic [1:0]          req_first;
    logic [2*WORD_W-1:0] req_data;
    logic                clear_start;
    logic                clear_busy;
    logic                clear_done;
    logic                rd_valid;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WORD_W-1:0]   rd_data;
    logic                wr_valid;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic                sat_flag;

    always #5 clk = ~clk;

    output_accum_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_first_i   (req_first),
        .req_data_i    (req_data),
        .clear_start_i (clear_start),
        .clear_busy_o  (clear_busy),
        .clear_done_o  (clear_done),
        .rd_valid_o    (rd_valid),
        .rd_addr_o     (rd_addr),
        .rd_data_i     (rd_data),
        .wr_valid_o    (wr_valid),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .sat_flag_o    (sat_flag)
    );

    // Two-port SRAM: registered read on port 1, write on port 2.
    logic [WORD_W-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (rd_valid) rd_data <= sram[rd_addr];
        else          rd_data <= {16{$urandom}};
        if (wr_valid) sram[wr_addr] <= wr_data;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [WORD_W-1:0] act, logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] rep(int v);
        logic [WORD_W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*LANE_W +: LANE_W] = 16'(v);
        return r;
    endfunction

    // Reference: each lane is plain integer addition clamped to 16-bit range.
    function automatic logic [WORD_W-1:0] model_add(logic [WORD_W-1:0] base,
                                                    logic [WORD_W-1:0] part,
                                                    output bit sat);
        logic [WORD_W-1:0] res;
        int s;
        sat = 1'b0;
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            s = int'($signed(base[l*LANE_W +: LANE_W])) + int'($signed(part[l*LANE_W +: LANE_W]));
            if (s > 32767) begin
                s = 32767; sat = 1'b1;
            end else if (s < -32768) begin
                s = -32768; sat = 1'b1;
            end
            res[l*LANE_W +: LANE_W] = 16'(s);
        end
        return res;
    endfunction

    typedef struct {
        int                addr;
        logic [WORD_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              q[$];
    logic [WORD_W-1:0] ref_mem [DEPTH];
    bit                ref_sat  = 1'b0;
    int                last_gnt = 0;

    // Scoreboard: on each accepted tile, check arbitration and the read
    // strobe, then predict the word written one cycle later.
    logic [1:0]        sb_g;
    int                sb_r;
    int                sb_a;
    bit                sb_f;
    bit                sb_s;
    logic [WORD_W-1:0] sb_d;
    logic [WORD_W-1:0] sb_base;
    logic [WORD_W-1:0] sb_sum;
    always @(negedge clk) begin
        if (reset) begin
            last_gnt = 0;
        end else begin
            sb_g = req_valid & req_ready;
            if (sb_g != 2'b00) begin
                if (sb_g == 2'b11) begin
                    checks++; errors++;
                    $display("FAIL grant_onehot: got %b expected a single grant", sb_g);
                end
                sb_r = sb_g[1] ? 1 : 0;
                if (req_valid == 2'b11) chk("rr_alternate", sb_r, 1 - last_gnt);
                last_gnt = sb_r;
                sb_a = int'(req_addr[sb_r*ADDR_W +: ADDR_W]);
                sb_f = req_first[sb_r];
                sb_d = req_data[sb_r*WORD_W +: WORD_W];
                chk("rd_valid", rd_valid, !sb_f);
                if (!sb_f) chk("rd_addr", rd_addr, sb_a);
                sb_base = sb_f ? '0 : ref_mem[sb_a];
                sb_sum  = model_add(sb_base, sb_d, sb_s);
                ref_mem[sb_a] = sb_sum;
                if (sb_s) ref_sat = 1'b1;
                q.push_back('{sb_a, sb_sum, cyc});
            end
        end
    end

    // Monitor: every tile write must match the oldest prediction.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && wr_valid && !clear_busy) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got write to %0d expected none", wr_addr);
            end else begin
                mon_e = q.pop_front();
                chk("wr_addr", wr_addr, mon_e.addr);
                chk("wr_data", wr_data, mon_e.data);
                chk("wr_latency", cyc, mon_e.cyc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(int r, int a, bit f, logic [WORD_W-1:0] d);
        int n = 0;
        req_valid[r] = 1'b1;
        req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(a);
        req_first[r] = f;
        req_data[r*WORD_W +: WORD_W] = d;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            @(negedge clk); n++;
        end
        if (!req_ready[r]) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no grant expected grant for requester %0d", r);
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    // Follows a sweep: bounded wait for entry, then 128 zero writes and done.
    task automatic sweep_check();
        int n = 0;
        @(negedge clk);
        while (!clear_busy && n < 10) begin
            chk("ready_pending", req_ready, 2'b00);
            @(negedge clk); n++;
        end
        chk("clear_entered", clear_busy, 1'b1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_sat = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            chk("clear_busy", clear_busy, 1'b1);
            chk("clear_wr", {wr_valid, rd_valid, req_ready}, 4'b1000);
            chk("clear_addr", wr_addr, i);
            chk("clear_data", wr_data, '0);
        end
        @(negedge clk);
        chk("clear_done", clear_done, 1'b1);
        chk("clear_busy_end", clear_busy, 1'b0);
        chk("sat_after_clear", sat_flag, 1'b0);
        @(negedge clk);
        chk("clear_done_pulse", clear_done, 1'b0);
    endtask

    initial begin
        int rem0;
        int rem1;
        int n;
        bit [1:0] gseen;

        reset       = 1'b1;
        req_valid   = 2'b11;
        req_addr    = '0;
        req_first   = '0;
        req_data    = '0;
        clear_start = 1'b0;
        repeat (3) tick();

        // Reset state, with both requesters asking
        @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_addr", rd_addr, '0);
        chk("rst_wr", {wr_valid, clear_busy, clear_done, sat_flag}, 4'b0000);
        chk("rst_wr_addr", wr_addr, '0);
        chk("rst_wr_data", wr_data, '0);
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 2'b00;
        tick();

        // Initial zero sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        sweep_check();
        tick();

        // First partial then accumulate two cycles later
        send(0, 5, 1'b1, rep(1));
        tick();
        send(0, 5, 1'b0, rep(2));
        repeat (3) tick();
        chk("word5", sram[5], rep(3));

        // Both requesters hammer address 9
        req_addr  = {ADDR_W'(9), ADDR_W'(9)};
        req_first = 2'b00;
        req_data  = {rep(1), rep(1)};
        req_valid = 2'b11;
        rem0 = 4; rem1 = 4; n = 0;
        while ((rem0 > 0 || rem1 > 0) && n < 40) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) rem0--;
            if (req_valid[1] && req_ready[1]) rem1--;
            @(posedge clk); #1;
            if (rem0 == 0) req_valid[0] = 1'b0;
            if (rem1 == 0) req_valid[1] = 1'b0;
            n++;
        end
        req_valid = 2'b00;
        chk("contend_done", (rem0 == 0 && rem1 == 0), 1'b1);
        repeat (3) tick();
        chk("word9", sram[9], rep(8));

        // Saturation at both ends
        send(0, 20, 1'b1, rep(32760));
        send(1, 20, 1'b0, rep(100));
        send(0, 21, 1'b1, rep(-32768));
        send(1, 21, 1'b0, rep(-1));
        repeat (3) tick();
        chk("word20_sat_pos", sram[20], rep(32767));
        chk("word21_sat_neg", sram[21], rep(-32768));
        chk("sat_flag_set", sat_flag, 1'b1);

        // Randomized traffic over a small address window
        gseen = 2'b00;
        for (int k = 0; k < 300; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] || gseen[r]) begin
                    req_valid[r] = ($urandom_range(0, 3) != 0);
                    req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
                    req_first[r] = ($urandom_range(0, 5) == 0);
                    for (int l = 0; l < LANES; l++)
                        req_data[r*WORD_W + l*LANE_W +: LANE_W] = 16'($urandom);
                end
            end
            @(negedge clk);
            gseen = req_valid & req_ready;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (3) tick();
        chk("sat_flag_random", sat_flag, ref_sat);
        for (int a = 0; a < 8; a++) chk("random_word", sram[a], ref_mem[a]);

        // Clear requested while both requesters are streaming
        req_addr  = {ADDR_W'(31), ADDR_W'(30)};
        req_first = 2'b00;
        req_data  = {rep(5), rep(3)};
        req_valid = 2'b11;
        tick();
        tick();
        chk("sat_before_clear", sat_flag, 1'b1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        sweep_check();
        repeat (6) tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("word30_after_clear", sram[30], ref_mem[30]);
        chk("word31_after_clear", sram[31], ref_mem[31]);

        // Reset in the middle of a sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(clear_busy && wr_addr == ADDR_W'(40)) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("reached_addr40", {clear_busy, wr_addr}, {1'b1, ADDR_W'(40)});
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wr_valid", wr_valid, 1'b0);
        chk("abort_busy", clear_busy, 1'b0);
        chk("abort_done", clear_done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {wr_valid, clear_busy, clear_done, sat_flag}, 4'b0000);
        end

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
